// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the four mux requesters and the round-robin arbiter.
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    // Requester side: raises requests, observes the grant.
    modport master (
        output req,
        input  gnt,
        input  sel,
        input  busy,
        input  preempt
    );

    // Arbiter side: samples requests, drives grant and mux select.
    modport slave (
        input  req,
        output gnt,
        output sel,
        output busy,
        output preempt
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux. Issues a registered one-hot
// grant, drives the mux select to match it, and rotates the grant after
// MAX_HOLD consecutive cycles when another requester is waiting.
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    mux_rr_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last cycle of a hold window; reaching it with others waiting forces a handover.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q,   gnt_d;
    logic [1:0]       sel_q,   sel_d;
    logic [1:0]       last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             preempt_q, preempt_d;

    // Winner search results: any requester vs. everyone except the current owner.
    logic             any_found,   other_found;
    logic [1:0]       any_idx,     other_idx;

    // Search last+1, last+2, last+3, then last itself unless skip_from is set.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] from,
                                           input logic       skip_from);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int j = 1; j <= 4; j++) begin
            cand = from + 2'(j);
            if (!found && req[cand] && !(skip_from && j == 4)) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign {any_found,   any_idx}   = rr_pick(bus.req, last_q, 1'b0);
    assign {other_found, other_idx} = rr_pick(bus.req, last_q, 1'b1);

    // Next-state and next-output decision for the grant FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << any_idx;
                    sel_d   = any_idx;
                    last_d  = any_idx;
                    cnt_d   = '0;
                end
            end

            GRANT: begin
                // In GRANT the owner is always last_q.
                if (!bus.req[last_q]) begin
                    // Owner released: hand over on this edge, or go idle.
                    if (any_found) begin
                        gnt_d  = 4'b0001 << any_idx;
                        sel_d  = any_idx;
                        last_d = any_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                    cnt_d = '0;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (other_found) begin
                    // Hold limit reached with someone waiting: take the grant away.
                    gnt_d     = 4'b0001 << other_idx;
                    sel_d     = other_idx;
                    last_d    = other_idx;
                    cnt_d     = '0;
                    preempt_d = 1'b1;
                end else begin
                    // Sole requester: keep the grant and start a fresh window.
                    cnt_d = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; reset drops any grant at once.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            last_q    <= 2'd3;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = |gnt_q;
    assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus randomized
// request traffic, all compared against a behavioural owner/hold-time model.
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Reference model: who owns the mux, for how many cycles, and who was last.
    int       m_owner;
    int       m_last;
    int       m_held;
    int       m_sel;
    bit       m_preempt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester in rotation order after 'from'; 'from' itself is tried last unless skipped.
    function automatic int rr_next(input logic [3:0] r, input int from, input bit skip_from);
        for (int j = 1; j <= 4; j++) begin
            int i;
            i = (from + j) % 4;
            if (j == 4 && skip_from) break;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_owner = w;
        m_last  = w;
        m_sel   = w;
        m_held  = 1;
    endtask

    // One clock edge of the arbitration rules.
    task automatic model_edge(input logic [3:0] r, input logic do_rst);
        int w;
        if (do_rst) begin
            m_owner   = -1;
            m_last    = 3;
            m_held    = 0;
            m_sel     = 0;
            m_preempt = 0;
            return;
        end
        m_preempt = 0;
        if (m_owner < 0) begin
            w = rr_next(r, m_last, 0);
            if (w >= 0) model_grant(w);
        end else if (!r[m_owner]) begin
            w = rr_next(r, m_owner, 0);
            if (w >= 0) model_grant(w);
            else m_owner = -1;
        end else if (m_held < MAX_HOLD) begin
            m_held++;
        end else begin
            w = rr_next(r, m_owner, 1);
            if (w >= 0) begin
                model_grant(w);
                m_preempt = 1;
            end else begin
                m_held = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner < 0) ? 4'b0000 : 4'(4'b0001 << m_owner);
        check("gnt",     32'(bus.gnt),     32'(exp_gnt));
        check("sel",     32'(bus.sel),     32'(m_sel));
        check("busy",    32'(bus.busy),    32'(m_owner >= 0));
        check("preempt", 32'(bus.preempt), 32'(m_preempt));
        check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    endtask

    // Drive one cycle of stimulus, advance the model on the edge, check mid-cycle.
    task automatic step(input logic [3:0] r, input logic do_rst);
        bus.req = r;
        rst     = do_rst;
        @(posedge clk);
        model_edge(r, do_rst);
        @(negedge clk);
        compare_all();
    endtask

    int         npre;
    logic [3:0] rq;

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        bus.req = 4'b0000;
        m_owner = -1;
        m_last  = 3;
        m_held  = 0;
        m_sel   = 0;
        m_preempt = 0;
        @(negedge clk);

        // Reset state.
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("rst_gnt",  32'(bus.gnt),  32'd0);
        check("rst_sel",  32'(bus.sel),  32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // Single requester 2, then release; sel keeps its value while idle.
        step(4'b0100, 1'b0);
        check("single_gnt", 32'(bus.gnt), 32'b0100);
        check("single_sel", 32'(bus.sel), 32'd2);
        step(4'b0000, 1'b0);
        check("release_gnt",  32'(bus.gnt),  32'd0);
        check("release_busy", 32'(bus.busy), 32'd0);
        check("release_sel",  32'(bus.sel),  32'd2);

        // Full contention from reset: 0,1,2,3,0... each for MAX_HOLD cycles.
        step(4'b0000, 1'b1);
        npre = 0;
        for (int c = 0; c < 40; c++) begin
            step(4'b1111, 1'b0);
            if (bus.preempt) npre++;
        end
        check("contend_preempts", 32'(npre), 32'd4);

        // Owner 1 with 3 waiting: release hands over with no bubble and no preempt.
        step(4'b0000, 1'b1);
        step(4'b0010, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b1000, 1'b0);
        check("handover_gnt",     32'(bus.gnt),     32'b1000);
        check("handover_sel",     32'(bus.sel),     32'd3);
        check("handover_preempt", 32'(bus.preempt), 32'd0);

        // Sole requester 2 for 20 cycles: grant never drops, never preempted.
        step(4'b0000, 1'b1);
        npre = 0;
        for (int c = 0; c < 20; c++) begin
            step(4'b0100, 1'b0);
            if (bus.preempt) npre++;
        end
        check("sole_gnt",      32'(bus.gnt), 32'b0100);
        check("sole_preempts", 32'(npre),    32'd0);

        // Reset while owner 3 is active; requester 0 is first afterwards.
        step(4'b0000, 1'b1);
        step(4'b1000, 1'b0);
        step(4'b1001, 1'b0);
        step(4'b1001, 1'b1);
        check("midrst_gnt",  32'(bus.gnt),  32'd0);
        check("midrst_sel",  32'(bus.sel),  32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        step(4'b1001, 1'b0);
        check("postrst_gnt", 32'(bus.gnt), 32'b0001);

        // Requester 1 releases, then 1 and 2 ask together: search starts at 2.
        step(4'b0000, 1'b1);
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0110, 1'b0);
        check("rr_after_release", 32'(bus.gnt), 32'b0100);

        // Randomized traffic with sticky requests and occasional resets.
        rq = 4'b0000;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) rq[b] = ~rq[b];
            step(rq, ($urandom_range(199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 select mux between four requesters. It samples a one-hot-free request vector and issues a registered one-hot grant, and it drives the mux `sel` to match the grant. A grant is held while its requester keeps `req` high, up to a hold limit, after which the grant rotates if anyone else is waiting. The block sits directly in front of the `mux` datapath and is the only driver of its `sel`.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester keeps the grant while others wait; legal range 1..255.
- `CNT_W`, default 8: hold-counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- `clk`  in  1  sole clock, all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req`  in  4  request per mux input; bit i = requester for input i (a,b,c,d = 0..3).
- `gnt`  out  4  registered one-hot grant; all-zero when idle.
- `sel`  out  2  mux select; equals index of the set `gnt` bit; holds its last value when idle.
- `busy`  out  1  high whenever `gnt` is non-zero.
- `preempt`  out  1  one-cycle pulse on the edge where a grant is taken away by the hold limit.

## Operation
- States: IDLE (no grant), GRANT (exactly one `gnt` bit set).
- Round-robin pointer `last` (2 bits) holds index of most recently granted requester. Search order for a new grant: last+1, last+2, last+3, last (mod 4). The first set `req` bit in that order wins.
- IDLE: if `req` != 0, go to GRANT with the winner; set `gnt`, `sel`, `last` = winner; hold count = 0. Else stay IDLE.
- GRANT, owner `k`:
  - `req[k]`=0 (release): pick the next winner from the remaining `req` bits using the search order from k. If one exists, grant it on the same edge with no idle bubble. If none exists, go to IDLE.
  - `req[k]`=1 and count < MAX_HOLD-1: keep the grant; count += 1.
  - `req[k]`=1, count == MAX_HOLD-1, other `req` bits set: grant the next winner (excluding k), reset count, pulse `preempt`.
  - `req[k]`=1, count == MAX_HOLD-1, no other requester: keep the grant; count wraps to 0; no `preempt`.
- Count is saturation-free: it never exceeds MAX_HOLD-1.
- `gnt` is always zero or one-hot. `sel` changes only when a new grant is issued.
- Reset values: `gnt`=0, `sel`=0, `busy`=0, `preempt`=0, state IDLE, count=0, `last`=3, so requester 0 has highest priority after reset.
- Reset mid-operation takes effect on the next rising edge regardless of state, and any grant is dropped immediately.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled at edge N, and `gnt`/`sel`/`busy` are valid after edge N.
- Release-to-handover is 1 cycle: `req[k]` low at edge N means the new owner is visible after edge N, and `gnt[k]` is already cleared.
- With continuous contention, each owner holds exactly MAX_HOLD cycles, then rotates.
- `preempt` is high for exactly the cycle following the preemption edge.
- No combinational path from `req` to any output.
- `sel` is stable for the whole grant window, so the mux output `y` reflects the owner's input for every cycle `gnt` is set.

## Test plan
- Reset, then only `req`=4'b0100 → one cycle later `gnt`=4'b0100, `sel`=2, `busy`=1; drop req → next cycle `gnt`=0, `busy`=0, `sel` stays 2.
- `req`=4'b1111 held from reset with MAX_HOLD=8 → grant order 0,1,2,3,0…, each exactly 8 cycles; `preempt` pulses at every handover after the first; `sel` follows 0,1,2,3.
- Owner 1 active and `req`=4'b1010; drop `req[1]` at cycle 3 → next cycle `gnt`=4'b1000, `sel`=3, no idle cycle, `preempt`=0.
- Sole requester 2 held for 20 cycles with MAX_HOLD=8 → `gnt`=4'b0100 continuously, `preempt` never asserts.
- Owner 3 active with `req`=4'b1001, assert `rst` for one cycle → after that edge `gnt`=0, `sel`=0, `busy`=0; after deasserting, requester 0 is granted first.
- Simultaneous `req`=4'b0110 immediately after requester 1 released → requester 2 is granted (search starts at last+1), not 1.
